dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
//
// PURPOSE
// Multi-cycle data-memory responder: the target end of the MemRead/MemWrite
// strobes driven by the main decoder. It accepts one word load/store at a time
// and holds stall high while the access completes. It returns load data with a
// one-cycle rvalid pulse and flags illegal requests. It sits between the
// datapath ALU result / rs2 value and the MemToReg write-back mux.
//
// PARAMETERS
// ADDR_W       10  word-address width; depth = 2**ADDR_W 32-bit words
// WAIT_CYCLES  2   extra wait states per access (0..15)
//
// PORTS
// clk        in   1   rising-edge clock
// rst_n      in   1   async active-low reset
// mem_read   in   1   load request (decoder MemRead)
// mem_write  in   1   store request (decoder MemWrite)
// addr       in   32  byte address (ALU result)
// wdata      in   32  store data (rs2)
// rdata      out  32  load data, valid while rvalid=1, held afterwards
// rvalid     out  1   one-cycle pulse: load data available
// stall      out  1   core must freeze PC/pipeline while high
// err        out  1   one-cycle pulse: request rejected
//
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE; rdata=0, rvalid=0, stall=0, err=0; wait counter=0.
//   - Memory array contents are not cleared.
//   - Reset during WAIT aborts the access; a pending store is not written.
// - req = mem_read | mem_write, sampled only in IDLE.
// - Illegal request, detected in IDLE:
//   - mem_read & mem_write both high, or addr[1:0]!=0, or addr[31:ADDR_W+2]!=0.
//   - Response: err=1 on the next cycle for one cycle, no memory access,
//     stall=0 throughout, stay in IDLE.
// - FSM states: IDLE, WAIT, DONE.
//   - IDLE, legal req: stall=1 combinationally in the same cycle.
//     - Latch op, word index addr[ADDR_W+1:2] and wdata.
//     - Load counter with WAIT_CYCLES.
//     - Go to WAIT, or to DONE if WAIT_CYCLES=0.
//   - WAIT: stall=1. Decrement the counter; go to DONE when the counter is 1.
//     Input changes are ignored, because the latched values are used.
//   - DONE: stall=0.
//     - Store: the array word is written at the DONE-entry edge.
//     - Load: rdata=mem[idx] and rvalid=1 for this cycle.
//     - Always returns to IDLE on the next edge.
// - Latency: request seen at cycle T -> stall high for cycles
//   T..T+WAIT_CYCLES -> DONE at T+WAIT_CYCLES+1.
// - Total stall cycles = WAIT_CYCLES+1.
// - In DONE the core advances, so a request first seen in IDLE at DONE+1
//   is a new access. Back-to-back accesses take WAIT_CYCLES+2 cycles each.
// - rdata keeps its last load value until the next load completes;
//   stores do not change rdata.
// - A load from a word never written returns X in sim, which is the bench's
//   concern. Read-after-write to the same word returns the new data.
// - err and rvalid are never high in the same cycle.
//
// TESTING
// - Store then load, WAIT_CYCLES=2:
//   - sw 0xDEADBEEF to 0x10 -> stall 3 cycles.
//   - lw 0x10 -> stall 3 cycles, then rvalid=1 and rdata=0xDEADBEEF.
// - Misaligned load at addr 0x13 -> err pulse 1 cycle, stall never high,
//   rdata unchanged.
// - mem_read=mem_write=1 at 0x20 -> err pulse; later lw 0x20 returns the
//   prior contents (no write happened).
// - Out-of-range addr 0x1000 (ADDR_W=10) -> err pulse, no access.
// - Abort a store mid-WAIT:
//   - sw 0x12345678 to 0x40; assert rst_n=0 in the WAIT cycle.
//   - All outputs go to 0 immediately.
//   - lw 0x40 after reset returns the old value, not 0x12345678.
// - WAIT_CYCLES=0 build: lw -> stall exactly 1 cycle, then rvalid=1.
// - Change addr/wdata during WAIT -> the original latched address and data
//   are used.

Source files
------------

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Multi-cycle single-word load/store target with stall, rvalid, err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        stall,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         c_DEPTH     = 2 ** ADDR_W;
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                is_load_q, is_load_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;

    logic [31:0]         mem [c_DEPTH];

    logic                w_req;
    logic                w_both;
    logic                w_misaligned;
    logic                w_oob;
    logic                w_illegal;
    logic                w_stall;
    logic                w_fin;
    logic                w_acc_load;
    logic [ADDR_W-1:0]   w_acc_idx;
    logic [31:0]         w_acc_wdata;
    logic                w_we;

    assign w_req        = mem_read | mem_write;
    assign w_both       = mem_read & mem_write;
    assign w_misaligned = |addr[1:0];

    generate
        if (ADDR_W + 2 < 32) begin : g_range_chk
            assign w_oob = |addr[31:ADDR_W+2];
        end else begin : g_range_full
            assign w_oob = 1'b0;
        end
    endgenerate

    assign w_illegal = w_both | w_misaligned | w_oob;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        idx_d       = idx_q;
        wdat_d      = wdat_q;
        err_d       = 1'b0;
        w_stall     = 1'b0;
        w_fin       = 1'b0;
        w_acc_load  = is_load_q;
        w_acc_idx   = idx_q;
        w_acc_wdata = wdat_q;

        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    if (w_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        w_stall   = 1'b1;
                        is_load_d = mem_read;
                        idx_d     = addr[ADDR_W+1:2];
                        wdat_d    = wdata;
                        cnt_d     = c_WAIT_INIT;
                        // With no wait states the access completes on this very
                        // edge, so the live inputs feed the array directly.
                        if (c_WAIT_INIT == 4'd0) begin
                            state_d     = S_DONE;
                            w_fin       = 1'b1;
                            w_acc_load  = mem_read;
                            w_acc_idx   = addr[ADDR_W+1:2];
                            w_acc_wdata = wdata;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_DONE;
                    w_fin   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A store lands on the edge that enters DONE; reset blocks it.
    assign w_we     = w_fin & ~w_acc_load & rst_n;
    assign rvalid_d = w_fin & w_acc_load;
    assign rdata_d  = (w_fin & w_acc_load) ? mem[w_acc_idx] : rdata_q;

    always_ff @(posedge clk) begin
        if (w_we) begin
            mem[w_acc_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            is_load_q <= 1'b0;
            idx_q     <= '0;
            wdat_q    <= 32'd0;
            rdata_q   <= 32'd0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            idx_q     <= idx_d;
            wdat_q    <= wdat_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign stall  = w_stall & rst_n;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Scoreboard bench for dmem_responder, WAIT_CYCLES=2 and 0 builds.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        mem_read2, mem_write2;
    logic [31:0] addr2, wdata2;
    logic [31:0] rdata2;
    logic        rvalid2, stall2, err2;

    logic        mem_read0, mem_write0;
    logic [31:0] addr0, wdata0;
    logic [31:0] rdata0;
    logic        rvalid0, stall0, err0;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    int errors = 0;
    int checks = 0;
    logic [31:0] last_rdata2;

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read2),
        .mem_write (mem_write2),
        .addr      (addr2),
        .wdata     (wdata2),
        .rdata     (rdata2),
        .rvalid    (rvalid2),
        .stall     (stall2),
        .err       (err2)
    );

    dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read0),
        .mem_write (mem_write0),
        .addr      (addr0),
        .wdata     (wdata0),
        .rdata     (rdata0),
        .rvalid    (rvalid0),
        .stall     (stall0),
        .err       (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            mem_read0 = rd; mem_write0 = wr; addr0 = a; wdata0 = d;
        end else begin
            mem_read2 = rd; mem_write2 = wr; addr2 = a; wdata2 = d;
        end
    endtask

    // Issues one request and counts stall cycles until the DONE/idle cycle.
    task automatic access(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_stall, input bit scramble, input string name);
        int   n;
        bit   done;
        logic s;
        n    = 0;
        done = 1'b0;
        @(posedge clk); #1;
        drive(sel, rd, wr, a, d);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            s = sel ? stall0 : stall2;
            if (s) begin
                n++;
                @(posedge clk); #1;
                if (scramble) drive(sel, 1'b0, 1'b0, $urandom, $urandom);
                else          drive(sel, 1'b0, 1'b0, a, d);
            end else begin
                done = 1'b1;
            end
        end
        check32({name, " stall cycles"}, 32'(n), 32'(exp_stall));
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, a, d);
    endtask

    always @(negedge clk) begin
        if (rst_n && (err2 || rvalid2)) begin
            exp_t e;
            checks++;
            if (err2 && rvalid2) begin
                errors++;
                $display("FAIL w2 err+rvalid: got both high required exclusive");
            end else if (q2.size() == 0) begin
                errors++;
                $display("FAIL w2 unexpected event: got err=%0b rvalid=%0b required none", err2, rvalid2);
            end else begin
                e = q2.pop_front();
                if (e.is_err != err2 || (!e.is_err && rdata2 !== e.data)) begin
                    errors++;
                    $display("FAIL w2 response: got err=%0b rdata=0x%08h required err=%0b rdata=0x%08h",
                             err2, rdata2, e.is_err, e.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (err0 || rvalid0)) begin
            exp_t e;
            checks++;
            if (err0 && rvalid0) begin
                errors++;
                $display("FAIL w0 err+rvalid: got both high required exclusive");
            end else if (q0.size() == 0) begin
                errors++;
                $display("FAIL w0 unexpected event: got err=%0b rvalid=%0b required none", err0, rvalid0);
            end else begin
                e = q0.pop_front();
                if (e.is_err != err0 || (!e.is_err && rdata0 !== e.data)) begin
                    errors++;
                    $display("FAIL w0 response: got err=%0b rdata=0x%08h required err=%0b rdata=0x%08h",
                             err0, rdata0, e.is_err, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check32("reset rdata",  rdata2, 32'd0);
        check32("reset rvalid", 32'(rvalid2), 32'd0);
        check32("reset stall",  32'(stall2),  32'd0);
        check32("reset err",    32'(err2),    32'd0);
        check32("reset rdata0", rdata0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata2 = 32'd0;

        // Zero-wait-state build
        access(1'b1, 1'b0, 1'b1, 32'h8, 32'h11223344, 1, 1'b0, "w0 sw 0x8");
        q0.push_back('{1'b0, 32'h11223344});
        access(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1, 1'b0, "w0 lw 0x8");
        q0.push_back('{1'b1, 32'h0});
        access(1'b1, 1'b1, 1'b0, 32'h6, 32'h0, 0, 1'b0, "w0 lw misaligned");

        // Two-wait-state build
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, 1'b0, "sw 0x10");
        q2.push_back('{1'b0, 32'hDEADBEEF});
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, "lw 0x10");
        last_rdata2 = 32'hDEADBEEF;

        q2.push_back('{1'b1, 32'h0});
        access(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 0, 1'b0, "lw misaligned 0x13");
        @(negedge clk);
        check32("rdata after misaligned", rdata2, last_rdata2);

        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 3, 1'b0, "sw 0x20");
        q2.push_back('{1'b1, 32'h0});
        access(1'b0, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 0, 1'b0, "rd+wr 0x20");
        q2.push_back('{1'b0, 32'h0BADF00D});
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3, 1'b0, "lw 0x20");
        last_rdata2 = 32'h0BADF00D;

        q2.push_back('{1'b1, 32'h0});
        access(1'b0, 1'b0, 1'b1, 32'h1000, 32'h55555555, 0, 1'b0, "sw out of range");

        access(1'b0, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 3, 1'b1, "sw 0x80 scrambled");
        @(negedge clk);
        check32("rdata after store", rdata2, last_rdata2);
        q2.push_back('{1'b0, 32'hCAFEF00D});
        access(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 3, 1'b1, "lw 0x80 scrambled");
        q2.push_back('{1'b0, 32'hDEADBEEF});
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, 1'b0, "lw 0x10 again");

        // Store aborted by reset while waiting
        access(1'b0, 1'b0, 1'b1, 32'h40, 32'hAAAA5555, 3, 1'b0, "sw 0x40");
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'h12345678);
        @(negedge clk);
        check32("abort stall before reset", 32'(stall2), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h40, 32'h12345678);
        #2;
        rst_n = 1'b0;
        #1;
        check32("abort rdata",  rdata2, 32'd0);
        check32("abort rvalid", 32'(rvalid2), 32'd0);
        check32("abort stall",  32'(stall2),  32'd0);
        check32("abort err",    32'(err2),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_rdata2 = 32'd0;
        q2.push_back('{1'b0, 32'hAAAA5555});
        access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 3, 1'b0, "lw 0x40 after abort");

        repeat (5) @(posedge clk);
        #1;
        check32("w2 queue drained", 32'(q2.size()), 32'd0);
        check32("w0 queue drained", 32'(q0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
